// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared defaults, read-mode constants and sizing helper for the
//               parametrised single-clock FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    localparam int c_default_width = 8;
    localparam int c_default_depth = 16;

    // Read-mode selectors for the FWFT parameter
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Fill count must represent 0..DEPTH, hence one bit more than a pointer
    function automatic int count_width(input int ptr_width);
        return ptr_width + 1;
    endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem_2p
// Description : DEPTH x WIDTH register array, synchronous write port and
//               asynchronous read port. Contents are never cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem_2p #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [PTR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [PTR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: store on enable, no reset so the array maps onto plain flops/RAM
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule : fifo_mem_2p
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with fill count, programmable
//               almost-full/almost-empty thresholds, synchronous flush and a
//               selectable standard or first-word-fall-through read stage.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int DEPTH     = c_default_depth,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = MODE_STD
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic                 wr_error_o,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 rd_valid_o,
    output logic                 empty_o,
    output logic                 almost_empty_o,
    output logic                 rd_error_o,
    output logic [PTR_WIDTH:0]   count_o
);

    localparam int c_cnt_w = count_width(PTR_WIDTH);

    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_afull_th  = c_cnt_w'(AFULL_TH);
    localparam logic [c_cnt_w-1:0] c_aempty_th = c_cnt_w'(AEMPTY_TH);

    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_wr_error;
    logic                 r_rd_error;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_rd_accept;
    logic                 w_wr_accept;
    logic                 w_mem_we;
    logic [WIDTH-1:0]     w_mem_rdata;

    // Flags come straight from the count register
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // A write into a full FIFO is still accepted when a read frees a slot
    // in the same cycle
    assign w_rd_accept = rd_en_i && !w_empty;
    assign w_wr_accept = wr_en_i && (!w_full || w_rd_accept);

    // Reset and flush both discard any request made in their cycle
    assign w_mem_we = w_wr_accept && rst_n_i && !flush_i;

    fifo_mem_2p #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (w_mem_we),
        .waddr_i (r_wr_ptr),
        .wdata_i (wdata_i),
        .raddr_i (r_rd_ptr),
        .rdata_o (w_mem_rdata)
    );

    // Pointers, fill count and one-cycle error pulses
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_error <= 1'b0;
            r_rd_error <= 1'b0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_error <= 1'b0;
            r_rd_error <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_wr_error <= wr_en_i && !w_wr_accept;
            r_rd_error <= rd_en_i && !w_rd_accept;
        end
    end

    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (r_count >= c_afull_th);
    assign almost_empty_o = (r_count <= c_aempty_th);
    assign wr_error_o     = r_wr_error;
    assign rd_error_o     = r_rd_error;
    assign count_o        = r_count;

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head of queue is presented directly; zero while empty so the
            // output matches its reset value
            assign rdata_o    = w_empty ? '0 : w_mem_rdata;
            assign rd_valid_o = !w_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_rdata;
            logic             r_rd_valid;

            // Registered read: capture the head on an accepted read, hold otherwise
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    r_rdata    <= '0;
                    r_rd_valid <= 1'b0;
                end else if (flush_i) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_accept;
                    if (w_rd_accept) begin
                        r_rdata <= w_mem_rdata;
                    end
                end
            end

            assign rdata_o    = r_rdata;
            assign rd_valid_o = r_rd_valid;
        end
    endgenerate

endmodule : sync_fifo_param
`default_nettype wire
